// File: rtl/grace_pkg.sv
// Shared types and constants for the Grace bus master bridge and its
// clock-enable generator.
package grace_pkg;

  typedef enum logic [1:0] {
    ST_OK  = 2'd0,
    ST_RE  = 2'd1,
    ST_OT  = 2'd2,
    ST_LTO = 2'd3
  } grace_status_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    RSP  = 2'd3
  } grace_state_e;

  localparam logic [31:0] FILL_OT  = 32'hCA04CA04;
  localparam logic [31:0] FILL_LTO = 32'hCA04CA05;

  // Number of bits needed to hold the value (at least one).
  function automatic int BitSize(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 31; i++) begin
      if ((value >> i) != 0) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/grace_master_if.sv
// Command/response port plus the Grace upstream bus of the master bridge.
// The master modport is the bridge's view; slave is the host/aggregator side.
interface grace_master_if #(
  parameter int AW = 4,
  parameter int DW = 32,
  parameter int WN = 1
) ();

  logic          Cmd_Vd;
  logic          Cmd_Rd;
  logic          Cmd_Wr;
  logic [AW-1:0] Cmd_Ad;
  logic [DW-1:0] Cmd_WD;
  logic          Rsp_Vd;
  logic          Rsp_Rd;
  logic [DW-1:0] Rsp_RD;
  logic [1:0]    Rsp_St;
  logic          Irq_Lv;
  logic          Irq_Pl;
  logic          M_Grace_Rs;
  logic          M_Grace_Ck;
  logic          M_Grace_CE;
  logic          M_Grace_CS;
  logic [WN-1:0] M_Grace_WR;
  logic [AW-1:0] M_Grace_Ad;
  logic [DW-1:0] M_Grace_WD;
  logic          M_Grace_Ac;
  logic          M_Grace_Re;
  logic [DW-1:0] M_Grace_RD;
  logic          M_Grace_IR;
  logic          M_Grace_OT;

  modport master (
    input  Cmd_Vd, Cmd_Wr, Cmd_Ad, Cmd_WD, Rsp_Rd,
    input  M_Grace_Ac, M_Grace_Re, M_Grace_RD, M_Grace_IR, M_Grace_OT,
    output Cmd_Rd, Rsp_Vd, Rsp_RD, Rsp_St, Irq_Lv, Irq_Pl,
    output M_Grace_Rs, M_Grace_Ck, M_Grace_CE, M_Grace_CS,
    output M_Grace_WR, M_Grace_Ad, M_Grace_WD
  );

  modport slave (
    output Cmd_Vd, Cmd_Wr, Cmd_Ad, Cmd_WD, Rsp_Rd,
    output M_Grace_Ac, M_Grace_Re, M_Grace_RD, M_Grace_IR, M_Grace_OT,
    input  Cmd_Rd, Rsp_Vd, Rsp_RD, Rsp_St, Irq_Lv, Irq_Pl,
    input  M_Grace_Rs, M_Grace_Ck, M_Grace_CE, M_Grace_CS,
    input  M_Grace_WR, M_Grace_Ad, M_Grace_WD
  );

endinterface

// File: rtl/grace_ce_gen.sv
// Grace clock-enable generator: a registered CE pulse once every CED clocks,
// continuously high when CED is 1.
module grace_ce_gen
  import grace_pkg::*;
#(
  parameter int CED = 1
) (
  input  logic Grace_Ck,
  input  logic Grace_Rs,
  output logic CE
);

  localparam int            CW   = BitSize(CED);
  localparam logic [CW-1:0] LAST = CW'(CED - 1);

  logic [CW-1:0] count;

  always_ff @(posedge Grace_Ck) begin
    if (Grace_Rs) begin
      count <= '0;
      CE    <= 1'b0;
    end else if (count == LAST) begin
      count <= '0;
      CE    <= 1'b1;
    end else begin
      count <= count + CW'(1);
      CE    <= 1'b0;
    end
  end

endmodule

// File: rtl/grace_master.sv
// Grace bus master bridge: one single-beat command at a time is turned into a
// Grace transaction, and its data/status is returned on the response port.
module grace_master
  import grace_pkg::*;
#(
  parameter int AW  = 4,
  parameter int DW  = 32,
  parameter int WN  = 1,
  parameter int CED = 1,
  parameter int LTO = 1023,
  parameter int IL  = 1
) (
  input  logic           Grace_Ck,
  input  logic           Grace_Rs,
  grace_master_if.master bus
);

  localparam int             WDW        = BitSize(LTO);
  localparam logic [WDW-1:0] WD_LIMIT   = WDW'(LTO);
  localparam logic           IRQ_ACTIVE = (IL != 0);

  grace_state_e   state, state_n;
  logic           ce;
  logic           cmd_rd, cmd_rd_n;
  logic           lat_wr, lat_wr_n;
  logic [AW-1:0]  lat_ad, lat_ad_n;
  logic [DW-1:0]  lat_wd, lat_wd_n;
  logic           cs, cs_n;
  logic [WN-1:0]  wr, wr_n;
  logic [AW-1:0]  ad, ad_n;
  logic [DW-1:0]  wd, wd_n;
  logic           rsp_vd, rsp_vd_n;
  logic [DW-1:0]  rsp_data, rsp_data_n;
  grace_status_e  rsp_st, rsp_st_n;
  logic [WDW-1:0] wdog, wdog_n, wdog_inc;
  logic           irq_hit, irq_lv, irq_pl;

  grace_ce_gen #(
    .CED(CED)
  ) u_ce_gen (
    .Grace_Ck(Grace_Ck),
    .Grace_Rs(Grace_Rs),
    .CE      (ce)
  );

  always_ff @(posedge Grace_Ck) begin
    if (Grace_Rs) begin
      state    <= IDLE;
      cmd_rd   <= 1'b0;
      lat_wr   <= 1'b0;
      lat_ad   <= '0;
      lat_wd   <= '0;
      cs       <= 1'b0;
      wr       <= '0;
      ad       <= '0;
      wd       <= '0;
      rsp_vd   <= 1'b0;
      rsp_data <= '0;
      rsp_st   <= ST_OK;
      wdog     <= '0;
    end else begin
      state    <= state_n;
      cmd_rd   <= cmd_rd_n;
      lat_wr   <= lat_wr_n;
      lat_ad   <= lat_ad_n;
      lat_wd   <= lat_wd_n;
      cs       <= cs_n;
      wr       <= wr_n;
      ad       <= ad_n;
      wd       <= wd_n;
      rsp_vd   <= rsp_vd_n;
      rsp_data <= rsp_data_n;
      rsp_st   <= rsp_st_n;
      wdog     <= wdog_n;
    end
  end

  // Bus outputs only move on CE clocks; an acknowledge beats a watchdog
  // expiry on the same clock because it is tested first.
  always_comb begin
    state_n    = state;
    lat_wr_n   = lat_wr;
    lat_ad_n   = lat_ad;
    lat_wd_n   = lat_wd;
    cs_n       = cs;
    wr_n       = wr;
    ad_n       = ad;
    wd_n       = wd;
    rsp_vd_n   = rsp_vd;
    rsp_data_n = rsp_data;
    rsp_st_n   = rsp_st;
    wdog_n     = wdog;
    wdog_inc   = (wdog == WD_LIMIT) ? wdog : wdog + WDW'(1);

    case (state)
      IDLE: begin
        if (bus.Cmd_Vd && cmd_rd) begin
          lat_wr_n = bus.Cmd_Wr;
          lat_ad_n = bus.Cmd_Ad;
          lat_wd_n = bus.Cmd_WD;
          wdog_n   = '0;
          state_n  = REQ;
        end
      end
      REQ: begin
        if (ce) begin
          if (!cs) begin
            cs_n = 1'b1;
            ad_n = lat_ad;
            wd_n = lat_wd;
            wr_n = {WN{lat_wr}};
          end else if (bus.M_Grace_Ac) begin
            cs_n       = 1'b0;
            wr_n       = '0;
            rsp_data_n = lat_wr ? '0 : bus.M_Grace_RD;
            if (bus.M_Grace_OT)      rsp_st_n = ST_OT;
            else if (bus.M_Grace_Re) rsp_st_n = ST_RE;
            else                     rsp_st_n = ST_OK;
            state_n    = GAP;
          end else if (wdog_inc == WD_LIMIT) begin
            cs_n       = 1'b0;
            wr_n       = '0;
            wdog_n     = wdog_inc;
            rsp_data_n = DW'(FILL_LTO);
            rsp_st_n   = ST_LTO;
            state_n    = GAP;
          end else begin
            wdog_n = wdog_inc;
          end
        end
      end
      GAP: begin
        // The aggregator's Ac is registered; wait until it has fallen.
        if (ce && !bus.M_Grace_Ac) begin
          rsp_vd_n = 1'b1;
          state_n  = RSP;
        end
      end
      RSP: begin
        if (bus.Rsp_Rd) begin
          rsp_vd_n = 1'b0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    cmd_rd_n = (state_n == IDLE);
  end

  assign irq_hit = (bus.M_Grace_IR == IRQ_ACTIVE);

  always_ff @(posedge Grace_Ck) begin
    if (Grace_Rs) begin
      irq_lv <= 1'b0;
      irq_pl <= 1'b0;
    end else if (ce) begin
      irq_lv <= irq_hit;
      irq_pl <= irq_hit && !irq_lv;
    end else begin
      irq_pl <= 1'b0;
    end
  end

  assign bus.Cmd_Rd     = cmd_rd;
  assign bus.Rsp_Vd     = rsp_vd;
  assign bus.Rsp_RD     = rsp_data;
  assign bus.Rsp_St     = rsp_st;
  assign bus.Irq_Lv     = irq_lv;
  assign bus.Irq_Pl     = irq_pl;
  assign bus.M_Grace_Rs = Grace_Rs;
  assign bus.M_Grace_Ck = Grace_Ck;
  assign bus.M_Grace_CE = ce;
  assign bus.M_Grace_CS = cs;
  assign bus.M_Grace_WR = wr;
  assign bus.M_Grace_Ad = ad;
  assign bus.M_Grace_WD = wd;

endmodule
